quad_enc_step_gen: RTL
======================

Name: quad_enc_step_gen

Overview:
- Upstream stage of the INC_DEC_REG up/down counter. Converts raw asynchronous quadrature encoder pins (A/B) into single-cycle, mutually exclusive INC_CE/DEC_CE pulses for the counter.
- Contains input synchronisation, per-channel glitch filtering, quadrature transition decoding, and a detent accumulator that emits one pulse per STEPS_PER_DETENT valid transitions.
- Illegal transitions are flagged on ERR.

Parameters:
- FILTER_CYCLES, 4: consecutive cycles a synchronised channel must differ from its filtered value before the filtered value flips. Legal range 1..255.
- STEPS_PER_DETENT, 4: valid quadrature transitions per output pulse. Legal values 1, 2, 4.

Ports:
- CLK  input  1  system clock, rising edge.
- CLR_N  input  1  synchronous active-low reset.
- ENABLE  input  1  high = pulses may be emitted.
- ENC_A  input  1  raw encoder channel A, asynchronous.
- ENC_B  input  1  raw encoder channel B, asynchronous.
- INC_CE  output  1  one-cycle increment strobe; connects to counter INC_CE.
- DEC_CE  output  1  one-cycle decrement strobe; connects to counter DEC_CE.
- ERR  output  1  one-cycle strobe on an illegal (double-bit) transition.

Behaviour:
- Reset (CLR_N low at a CLK edge):
  - INC_CE=0, DEC_CE=0, ERR=0.
  - Sync registers, filtered A/B, previous A/B, filter counters and accumulator all cleared.
  - FSM enters INIT.
- Synchroniser: two flops per channel (s1, s2). The raw level reaches s2 two edges after first sampling.
- FSM states:
  - INIT: a 2-cycle counter lets s2 become valid. On the 2nd cycle, filtered A/B and previous A/B are loaded directly from s2, with no pulses and no ERR. Next state is RUN.
  - RUN: normal operation.
  - CLR_N low in any state returns the FSM to INIT. There is no other exit from RUN.
- Filter, per channel, in RUN:
  - If s2 equals the filtered value, the counter is cleared to 0.
  - Otherwise the counter increments. When it would reach FILTER_CYCLES, the filtered value takes s2 and the counter clears.
  - The filtered value therefore changes exactly FILTER_CYCLES edges after s2 first shows the new level.
  - A mismatch shorter than FILTER_CYCLES cycles is discarded.
- Decode: each cycle, compare prev={A,B} with cur={A,B} filtered, then set prev<=cur.
  - Forward (+1) sequence: 00->01->11->10->00.
  - Reverse (-1) sequence: 00->10->11->01->00.
  - Both bits changed: illegal. ERR=1 for one cycle, accumulator cleared to 0, no INC/DEC.
  - No change: no action.
- Accumulator: signed, range -(STEPS_PER_DETENT-1)..+(STEPS_PER_DETENT-1), reset 0.
  - On +1: if acc==STEPS_PER_DETENT-1, then INC_CE=1 and acc=0; else acc+1.
  - On -1: if acc==-(STEPS_PER_DETENT-1), then DEC_CE=1 and acc=0; else acc-1.
  - A direction reversal simply moves acc back toward 0.
  - With STEPS_PER_DETENT=1, every valid transition pulses.
- Outputs are registered. A pulse appears on the edge after the filtered value changes.
  - Total latency = 2 (sync) + FILTER_CYCLES + 1 edges from the first edge sampling the new pin level.
- INC_CE and DEC_CE are never high simultaneously. At most one of INC_CE/DEC_CE/ERR is high in a cycle. Every pulse is exactly one cycle wide.
- ENABLE low:
  - Filter and prev tracking continue; acc is held at 0.
  - INC_CE/DEC_CE/ERR are forced to 0.
  - Re-enabling never produces a pulse for motion that occurred while disabled.
- Reset mid-sequence discards the partial accumulation and any in-progress filter count. No pulse is emitted for it.

Test Plan:
- Reset with pins A=1,B=1 held, ENABLE=1, FILTER_CYCLES=4 -> INIT seeds prev=11; no ERR, INC_CE or DEC_CE in the 20 cycles after reset release.
- STEPS_PER_DETENT=4, forward sequence 00->01->11->10->00, each level held 10 cycles -> exactly one INC_CE pulse, 7 cycles after the ENC change to 00; DEC_CE never asserted.
- STEPS_PER_DETENT=1, reverse sequence 00->10->11->01 -> three DEC_CE pulses, each 1 cycle wide, each 7 edges after its pin change.
- Glitch: ENC_A pulses high for 3 cycles (FILTER_CYCLES=4) -> filtered A unchanged, no strobes. The same pulse held 4 cycles -> the transition is accepted.
- Pins 00->11 simultaneously -> single ERR pulse, acc cleared. A following forward run of 4 valid steps from 11 yields exactly one INC_CE.
- ENABLE=0 during 4 forward steps, then ENABLE=1 with pins static -> no INC_CE. Then 4 more forward steps -> one INC_CE. Asserting CLR_N=0 after 2 forward steps -> no pulse, outputs 0 during reset.

Source files
------------

// File: rtl/quad_enc_step_gen.sv
// rtl/quad_enc_step_gen.sv - quadrature encoder to INC_CE/DEC_CE step pulse generator
// Sync, per-channel glitch filter, quadrature decode and detent accumulator.
module quad_enc_step_gen #(
  parameter int FILTER_CYCLES    = 4,
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic CLK,
  input  logic CLR_N,
  input  logic ENABLE,
  input  logic ENC_A,
  input  logic ENC_B,
  output logic INC_CE,
  output logic DEC_CE,
  output logic ERR
);

  localparam logic [7:0]        FC_LAST = 8'(FILTER_CYCLES - 1);
  localparam logic signed [3:0] ACC_MAX = 4'(STEPS_PER_DETENT - 1);
  localparam logic signed [3:0] ACC_MIN = -ACC_MAX;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [1:0]         r_init_cnt;
  logic               w_load;
  logic               w_run;
  logic [1:0]         r_s1;
  logic [1:0]         r_s2;
  logic [1:0]         r_filt;
  logic [1:0]         r_prev;
  logic [7:0]         r_fcnt [2];
  logic signed [3:0]  r_acc;
  logic [1:0]         w_prev_pos;
  logic [1:0]         w_cur_pos;
  logic [1:0]         w_delta;

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (r_state == ST_INIT && r_init_cnt == 2'd2) begin
      w_next_state = ST_RUN;
    end
  end

  // Seed waits until the raw level has propagated through both sync stages.
  always_comb begin
    w_load = 1'b0;
    w_run  = 1'b0;
    case (r_state)
      ST_INIT: w_load = (r_init_cnt == 2'd2);
      ST_RUN:  w_run  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      r_init_cnt <= 2'd0;
      r_s1       <= 2'b00;
      r_s2       <= 2'b00;
      r_filt     <= 2'b00;
      r_prev     <= 2'b00;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= 8'd0;
    end else begin
      r_s1 <= {ENC_A, ENC_B};
      r_s2 <= r_s1;
      if (r_state == ST_INIT && r_init_cnt != 2'd2) r_init_cnt <= r_init_cnt + 2'd1;
      if (w_load) begin
        r_filt <= r_s2;
        r_prev <= r_s2;
      end else if (w_run) begin
        r_prev <= r_filt;
        for (int i = 0; i < 2; i++) begin
          if (r_s2[i] == r_filt[i]) begin
            r_fcnt[i] <= 8'd0;
          end else if (r_fcnt[i] == FC_LAST) begin
            r_filt[i] <= r_s2[i];
            r_fcnt[i] <= 8'd0;
          end else begin
            r_fcnt[i] <= r_fcnt[i] + 8'd1;
          end
        end
      end
    end
  end

  // Gray code to position: forward motion adds 1 mod 4, a difference of 2 is illegal.
  assign w_prev_pos = {r_prev[1], r_prev[1] ^ r_prev[0]};
  assign w_cur_pos  = {r_filt[1], r_filt[1] ^ r_filt[0]};
  assign w_delta    = w_cur_pos - w_prev_pos;

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      r_acc  <= 4'sd0;
      INC_CE <= 1'b0;
      DEC_CE <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      INC_CE <= 1'b0;
      DEC_CE <= 1'b0;
      ERR    <= 1'b0;
      if (w_run && ENABLE) begin
        case (w_delta)
          2'd1: begin
            if (r_acc == ACC_MAX) begin
              INC_CE <= 1'b1;
              r_acc  <= 4'sd0;
            end else begin
              r_acc <= r_acc + 4'sd1;
            end
          end
          2'd3: begin
            if (r_acc == ACC_MIN) begin
              DEC_CE <= 1'b1;
              r_acc  <= 4'sd0;
            end else begin
              r_acc <= r_acc - 4'sd1;
            end
          end
          2'd2: begin
            ERR   <= 1'b1;
            r_acc <= 4'sd0;
          end
          default: ;
        endcase
      end else begin
        r_acc <= 4'sd0;
      end
    end
  end

endmodule
